threshold_monitor: RTL and testbench

THRESHOLD_MONITOR -- requirements
Module: threshold_monitor

---
 rtl/threshold_monitor.sv | 193 +++++++++++++++++++
 tb/tb_threshold_monitor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_monitor.sv
// Purpose : compares each accepted 4-bit sample against a programmable threshold
//           and raises a debounced "above threshold" alarm, counting alarm rises.
// Latency : one cycle from an accepted sample to gt/eq/lt, cmp_valid and alarm.
// Backpressure: none; every sample with sample_valid=1 is accepted that cycle.
//
// Parameters
//   DEBOUNCE   : consecutive qualifying samples needed to set or clear the alarm (1..15)
//   THRESH_RST : reset value of the threshold register
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   sample_valid      : qualifies sample for one cycle
//   sample            : unsigned 4-bit data sample
//   thresh_we         : loads thresh_in into the threshold register
//   thresh_in         : unsigned 4-bit new threshold
//   gt / eq / lt      : registered comparison of the last accepted sample
//   cmp_valid         : one-cycle pulse when gt/eq/lt update
//   alarm             : debounced "sample above threshold" level
//   alarm_rise        : one-cycle pulse on each entry into ALARM from IDLE/ARMING
//   event_cnt         : saturating count of alarm rises
// Configuration
//   THRESHOLD_MONITOR_EVENT_CNT_EN : when defined, event_cnt counts alarm rises
//   (saturating at 255); when undefined, event_cnt is tied to zero.

module threshold_monitor #(
    parameter int unsigned DEBOUNCE   = 3,
    parameter logic [3:0]  THRESH_RST = 4'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [3:0] sample,
    input  logic       thresh_we,
    input  logic [3:0] thresh_in,
    output logic       gt,
    output logic       eq,
    output logic       lt,
    output logic       cmp_valid,
    output logic       alarm,
    output logic       alarm_rise,
    output logic [7:0] event_cnt
);

    localparam logic [3:0] DEB = 4'(DEBOUNCE);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARMING   = 2'd1,
        S_ALARM    = 2'd2,
        S_CLEARING = 2'd3
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [3:0] cnt;
    logic [3:0] cnt_n;
    logic [3:0] cnt_inc;
    logic [3:0] thr;
    logic       above;
    logic       rise_n;

    // Threshold register. A sample accepted in the write cycle still sees
    // the old value because the comparison below reads thr, not thresh_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            thr <= THRESH_RST;
        end else if (thresh_we) begin
            thr <= thresh_in;
        end
    end

    // Only strictly greater counts as "above"; equal is treated as not-above.
    assign above   = (sample > thr);
    assign cnt_inc = cnt + 4'd1;

    // Comparison result registers; held between accepted samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            gt        <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
            cmp_valid <= 1'b0;
        end else begin
            cmp_valid <= sample_valid;
            if (sample_valid) begin
                gt <= (sample > thr);
                eq <= (sample == thr);
                lt <= (sample < thr);
            end
        end
    end

    // FSM state register. Threshold writes deliberately do not touch it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            alarm_rise <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            alarm_rise <= rise_n;
        end
    end

    // Next-state logic. Nothing moves without sample_valid, so idle gaps
    // never break a consecutive run.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rise_n  = 1'b0;
        if (sample_valid) begin
            case (state)
                S_IDLE: begin
                    if (above) begin
                        if (DEB == 4'd1) begin
                            state_n = S_ALARM;
                            cnt_n   = 4'd0;
                            rise_n  = 1'b1;
                        end else begin
                            state_n = S_ARMING;
                            cnt_n   = 4'd1;
                        end
                    end
                end
                S_ARMING: begin
                    if (above) begin
                        if (cnt_inc == DEB) begin
                            state_n = S_ALARM;
                            cnt_n   = 4'd0;
                            rise_n  = 1'b1;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = S_IDLE;
                        cnt_n   = 4'd0;
                    end
                end
                S_ALARM: begin
                    if (!above) begin
                        if (DEB == 4'd1) begin
                            state_n = S_IDLE;
                            cnt_n   = 4'd0;
                        end else begin
                            state_n = S_CLEARING;
                            cnt_n   = 4'd1;
                        end
                    end
                end
                S_CLEARING: begin
                    if (!above) begin
                        if (cnt_inc == DEB) begin
                            state_n = S_IDLE;
                            cnt_n   = 4'd0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        // Alarm never dropped, so returning here is not a rise.
                        state_n = S_ALARM;
                        cnt_n   = 4'd0;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = 4'd0;
                end
            endcase
        end
    end

    // Alarm is high in both states where the debounced level is "above".
    assign alarm = (state == S_ALARM) || (state == S_CLEARING);

`ifdef THRESHOLD_MONITOR_EVENT_CNT_EN
    // Counts on the same edge that registers alarm_rise, so event_cnt
    // reflects a rise in the same cycle the pulse is visible.
    logic [7:0] ev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_q <= 8'd0;
        end else if (rise_n && (ev_q != 8'hFF)) begin
            ev_q <= ev_q + 8'd1;
        end
    end

    assign event_cnt = ev_q;
`else
    assign event_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_threshold_monitor.sv
// Purpose : directed scoreboard bench for threshold_monitor (DEBOUNCE=3, thr reset 8).
// Latency : expectations are queued at issue and popped on each cmp_valid.
// Backpressure: none; the DUT accepts every sample.

module tb_threshold_monitor;

    logic       clk;
    logic       rst;
    logic       sample_valid;
    logic [3:0] sample;
    logic       thresh_we;
    logic [3:0] thresh_in;
    logic       gt;
    logic       eq;
    logic       lt;
    logic       cmp_valid;
    logic       alarm;
    logic       alarm_rise;
    logic [7:0] event_cnt;

    typedef struct packed {
        logic       gt;
        logic       eq;
        logic       lt;
        logic       alarm;
        logic       rise;
        logic [7:0] ev;
    } exp_t;

    exp_t q[$];
    exp_t last_exp;
    int   checks;
    int   errors;
    int   ev_model;

    threshold_monitor #(
        .DEBOUNCE   (3),
        .THRESH_RST (4'd8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .thresh_we    (thresh_we),
        .thresh_in    (thresh_in),
        .gt           (gt),
        .eq           (eq),
        .lt           (lt),
        .cmp_valid    (cmp_valid),
        .alarm        (alarm),
        .alarm_rise   (alarm_rise),
        .event_cnt    (event_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue one sample with hand-computed expected flags; optionally write
    // a new threshold in the same cycle.
    task automatic send_w(input logic [3:0] s, input logic we, input logic [3:0] tin,
                          input logic g, input logic e, input logic l,
                          input logic a, input logic r);
        exp_t x;
`ifdef THRESHOLD_MONITOR_EVENT_CNT_EN
        if (r && ev_model < 255) ev_model++;
`endif
        x.gt = g; x.eq = e; x.lt = l; x.alarm = a; x.rise = r;
        x.ev = 8'(ev_model);
        q.push_back(x);
        sample_valid = 1'b1;
        sample       = s;
        thresh_we    = we;
        thresh_in    = tin;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        thresh_we    = 1'b0;
    endtask

    task automatic send(input logic [3:0] s, input logic g, input logic e,
                        input logic l, input logic a, input logic r);
        send_w(s, 1'b0, 4'd0, g, e, l, a, r);
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_thr(input logic [3:0] tin);
        thresh_we = 1'b1;
        thresh_in = tin;
        @(posedge clk);
        #1;
        thresh_we = 1'b0;
    endtask

    // Reset with sample_valid and thresh_we also asserted: rst must win.
    task automatic do_reset();
        rst          = 1'b1;
        sample_valid = 1'b1;
        sample       = 4'd15;
        thresh_we    = 1'b1;
        thresh_in    = 4'd0;
        ev_model     = 0;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        sample_valid = 1'b0;
        thresh_we    = 1'b0;
    endtask

    // Clear a set alarm with three below-threshold samples.
    task automatic clear_alarm();
        send(4'd0, 0, 0, 1, 1, 0);
        send(4'd0, 0, 0, 1, 1, 0);
        send(4'd0, 0, 0, 1, 0, 0);
    endtask

    // Monitor: on cmp_valid pop and compare; otherwise outputs must hold
    // the last expected values with no alarm_rise.
    always @(negedge clk) begin
        if (rst) begin
            last_exp <= '0;
        end else if (cmp_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cmp_valid: got cmp_valid=1, required no pending sample");
            end else begin
                exp_t x;
                exp_t act;
                x = q.pop_front();
                act.gt = gt; act.eq = eq; act.lt = lt;
                act.alarm = alarm; act.rise = alarm_rise; act.ev = event_cnt;
                if (act !== x) begin
                    errors++;
                    $display("FAIL result: got gt%0b eq%0b lt%0b alarm%0b rise%0b ev%0d, required gt%0b eq%0b lt%0b alarm%0b rise%0b ev%0d",
                             act.gt, act.eq, act.lt, act.alarm, act.rise, act.ev,
                             x.gt, x.eq, x.lt, x.alarm, x.rise, x.ev);
                end
                last_exp <= x;
            end
        end else begin
            exp_t act;
            exp_t h;
            checks++;
            act.gt = gt; act.eq = eq; act.lt = lt;
            act.alarm = alarm; act.rise = alarm_rise; act.ev = event_cnt;
            h = last_exp;
            h.rise = 1'b0;
            if (act !== h || cmp_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold: got gt%0b eq%0b lt%0b alarm%0b rise%0b ev%0d, required gt%0b eq%0b lt%0b alarm%0b rise0 ev%0d",
                         act.gt, act.eq, act.lt, act.alarm, act.rise, act.ev,
                         h.gt, h.eq, h.lt, h.alarm, h.ev);
            end
        end
    end

    initial begin
        int budget;
        checks       = 0;
        errors       = 0;
        ev_model     = 0;
        last_exp     = '0;
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample       = 4'd0;
        thresh_we    = 1'b0;
        thresh_in    = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        gap(2);

        // Three consecutive 9s set the alarm on the third.
        send(4'd9, 1, 0, 0, 0, 0);
        send(4'd9, 1, 0, 0, 0, 0);
        send(4'd9, 1, 0, 0, 1, 1);

        // 3,3,12 returns to ALARM without a rise; then three 3s clear it.
        send(4'd3, 0, 0, 1, 1, 0);
        send(4'd3, 0, 0, 1, 1, 0);
        send(4'd12, 1, 0, 0, 1, 0);
        send(4'd3, 0, 0, 1, 1, 0);
        send(4'd3, 0, 0, 1, 1, 0);
        send(4'd3, 0, 0, 1, 0, 0);

        // Equal to threshold is not-above and restarts the run.
        send(4'd8, 0, 1, 0, 0, 0);
        send(4'd9, 1, 0, 0, 0, 0);
        send(4'd9, 1, 0, 0, 0, 0);
        send(4'd8, 0, 1, 0, 0, 0);
        send(4'd9, 1, 0, 0, 0, 0);
        send(4'd9, 1, 0, 0, 0, 0);
        send(4'd9, 1, 0, 0, 1, 1);
        clear_alarm();

        // Threshold write in the sample cycle: old thr=8 applies, then thr=2.
        send_w(4'd5, 1'b1, 4'd2, 0, 0, 1, 0, 0);
        send(4'd5, 1, 0, 0, 0, 0);              // ARMING cnt=1
        gap(1);
        write_thr(4'd8);                        // must not disturb ARMING
        send(4'd9, 1, 0, 0, 0, 0);              // cnt=2
        send(4'd9, 1, 0, 0, 1, 1);              // cnt=3 -> ALARM
        clear_alarm();

        // Gaps do not break a run.
        send(4'd10, 1, 0, 0, 0, 0);
        send(4'd10, 1, 0, 0, 0, 0);
        gap(4);
        send(4'd10, 1, 0, 0, 1, 1);
        clear_alarm();

        // Reset in ARMING discards the partial count; rst beats valid/we.
        send(4'd9, 1, 0, 0, 0, 0);
        send(4'd9, 1, 0, 0, 0, 0);
        gap(1);
        do_reset();
        gap(2);
        send(4'd8, 0, 1, 0, 0, 0);              // thr still 8 after reset
        send(4'd9, 1, 0, 0, 0, 0);
        send(4'd9, 1, 0, 0, 0, 0);
        send(4'd9, 1, 0, 0, 1, 1);
        clear_alarm();

        // Many set/clear cycles exercise event counter saturation.
        for (int i = 0; i < 300; i++) begin
            send(4'd15, 1, 0, 0, 0, 0);
            send(4'd15, 1, 0, 0, 0, 0);
            send(4'd15, 1, 0, 0, 1, 1);
            clear_alarm();
        end
        gap(2);

        checks++;
`ifdef THRESHOLD_MONITOR_EVENT_CNT_EN
        if (event_cnt !== 8'd255) begin
            errors++;
            $display("FAIL event_cnt_final: got %0d, required 255", event_cnt);
        end
`else
        if (event_cnt !== 8'd0) begin
            errors++;
            $display("FAIL event_cnt_final: got %0d, required 0", event_cnt);
        end
`endif

        budget = 20;
        while (q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results, required 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
